// File: rtl/hdma_mover.sv
// hdma_mover: fetches HDMA/GDMA source bytes from the system bus and writes them into VRAM.
module hdma_mover #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        hdma_active,
  input  logic        hdma_rd,
  input  logic [15:0] src_addr,
  input  logic [15:0] dst_addr,
  input  logic        vram_bank,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_valid,
  input  logic [7:0]  mem_data,
  input  logic        vram_busy,
  output logic        vram_we,
  output logic [12:0] vram_addr,
  output logic        vram_bank_o,
  output logic [7:0]  vram_wdata,
  output logic        cpu_halt,
  output logic [15:0] bytes_done,
  output logic        err
);
  localparam int TW = TIMEOUT > 2 ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;
  state_t state, state_nx;
  logic [15:0] last_src, pend_src, ld_src;
  logic [12:0] pend_dst, ld_dst;
  logic        pend_v, pend_bank, ld_bank;
  logic [TW-1:0] timer;
  logic new_byte, retire, free, load_pend, load_new, ld, queue, ld_vram, timeout;
  logic unused;
  assign unused = &{1'b0, dst_addr[15:13]};
  // A queued byte always goes before a freshly presented one; the fresh one is seen again later.
  always_comb begin
    new_byte  = hdma_rd & (src_addr != last_src);
    retire    = (state == WRITE) & ~vram_busy;
    free      = (state == IDLE) | retire;
    load_pend = free & pend_v & hdma_active;
    load_new  = free & ~load_pend & new_byte;
    ld        = load_pend | load_new;
    queue     = ~free & new_byte & ~pend_v & hdma_active;
    ld_src    = load_pend ? pend_src : src_addr;
    ld_dst    = load_pend ? pend_dst : dst_addr[12:0];
    ld_bank   = load_pend ? pend_bank : vram_bank;
    ld_vram   = ld_src[15:13] == 3'b100;
    timeout   = timer == TO_LAST;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else if (ce) state <= state_nx;
  always_comb begin
    state_nx = ld ? (ld_vram ? WRITE : REQ) :
               retire ? IDLE :
               (state == REQ) ? WAIT :
               (state == WAIT && (mem_valid || timeout)) ? WRITE : state;
  end
  always_comb begin
    mem_rd   = ce & ~reset & (state == REQ);
    vram_we  = ce & ~reset & retire;
    cpu_halt = hdma_active | (state != IDLE);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      last_src    <= 16'hFFFF;
      pend_v      <= 1'b0;
      pend_src    <= '0;
      pend_dst    <= '0;
      pend_bank   <= 1'b0;
      mem_addr    <= '0;
      vram_addr   <= '0;
      vram_bank_o <= 1'b0;
      vram_wdata  <= '0;
      timer       <= '0;
      bytes_done  <= '0;
      err         <= 1'b0;
    end else if (ce) begin
      last_src <= !hdma_rd ? 16'hFFFF : (load_new | queue) ? src_addr : last_src;
      pend_v   <= hdma_active & (queue | (pend_v & ~load_pend));
      if (queue) begin
        pend_src  <= src_addr;
        pend_dst  <= dst_addr[12:0];
        pend_bank <= vram_bank;
      end
      if (ld) begin
        vram_addr   <= ld_dst;
        vram_bank_o <= ld_bank;
        if (ld_vram) vram_wdata <= 8'hFF;
        else mem_addr <= (ld_src[15:13] == 3'b111) ? ld_src - 16'h2000 : ld_src;
      end
      if (state == REQ) timer <= '0;
      if (state == WAIT) begin
        if (mem_valid) vram_wdata <= mem_data;
        else if (timeout) begin
          vram_wdata <= 8'hFF;
          err        <= 1'b1;
        end else timer <= timer + 1'b1;
      end
      if (retire) bytes_done <= bytes_done + 16'd1;
    end
  end
endmodule

// File: tb/tb_hdma_mover.sv
// tb_hdma_mover: table-driven transfers plus hand sequences for busy, skid, ce and reset cases.
module tb_hdma_mover;
  logic clk = 1'b0;
  logic reset, ce, hdma_active, hdma_rd, vram_bank, vram_busy;
  logic [15:0] src_addr, dst_addr, mem_addr, bytes_done;
  logic mem_rd, vram_we, vram_bank_o, cpu_halt, err;
  logic mem_valid = 1'b0;
  logic [7:0] mem_data = 8'h00;
  logic [7:0] vram_wdata;
  logic [12:0] vram_addr;

  hdma_mover #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .ce(ce), .hdma_active(hdma_active), .hdma_rd(hdma_rd),
    .src_addr(src_addr), .dst_addr(dst_addr), .vram_bank(vram_bank), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_valid(mem_valid), .mem_data(mem_data), .vram_busy(vram_busy),
    .vram_we(vram_we), .vram_addr(vram_addr), .vram_bank_o(vram_bank_o),
    .vram_wdata(vram_wdata), .cpu_halt(cpu_halt), .bytes_done(bytes_done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, rd_cyc = 0, we_cyc = 0, exp_done = 0;
  bit bus_en = 1'b1;
  logic [21:0] wq[$];
  logic [15:0] rq[$];

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (vram_we) begin
      wq.push_back({vram_bank_o, vram_addr, vram_wdata});
      we_cyc = cyc;
    end
    if (mem_rd) begin
      rq.push_back(mem_addr);
      rd_cyc = cyc;
    end
  end

  always begin
    logic s;
    logic [15:0] a;
    @(negedge clk);
    s = mem_rd & bus_en;
    a = mem_addr;
    @(posedge clk);
    #1;
    mem_valid = s;
    mem_data = s ? pat(a) : 8'h00;
  end

  typedef struct {
    logic [15:0] src, dst;
    int n;
    logic bank;
    bit bus;
    int slot, exp_rd;
    logic [15:0] exp_ma;
    bit exp_ff;
    logic [12:0] exp_va;
    int exp_lat;
    logic exp_err;
  } vec_t;

  vec_t v[4];

  initial begin
    v[0] = '{16'h4000, 16'h8800, 32, 1'b0, 1'b1, 4, 32, 16'h4000, 1'b0, 13'h0800, 2, 1'b0};
    v[1] = '{16'h8100, 16'h9000, 16, 1'b1, 1'b1, 4, 0, 16'h0000, 1'b1, 13'h1000, 0, 1'b0};
    v[2] = '{16'hE010, 16'h8000, 16, 1'b0, 1'b1, 4, 16, 16'hC010, 1'b0, 13'h0000, 2, 1'b0};
    v[3] = '{16'h5000, 16'h9FFF, 1, 1'b1, 1'b0, 24, 1, 16'h5000, 1'b1, 13'h1FFF, 17, 1'b1};
    reset = 1'b1; ce = 1'b1; hdma_active = 1'b0; hdma_rd = 1'b0; vram_bank = 1'b0;
    vram_busy = 1'b0; src_addr = '0; dst_addr = '0;
    tick(2);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_vram_we", vram_we, 0);
    chk("rst_halt", cpu_halt, 0);
    chk("rst_done", bytes_done, 0);
    chk("rst_err", err, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_vaddr", vram_addr, 0);
    reset = 1'b0;
    tick(2);

    for (int k = 0; k < 4; k++) begin
      wq.delete(); rq.delete();
      bus_en = v[k].bus; vram_bank = v[k].bank; hdma_active = 1'b1;
      for (int i = 0; i < v[k].n; i++) begin
        src_addr = v[k].src + 16'(i);
        dst_addr = v[k].dst + 16'(i);
        hdma_rd = 1'b1;
        tick(v[k].slot);
      end
      chk("halt_active", cpu_halt, 1);
      hdma_rd = 1'b0; hdma_active = 1'b0;
      tick(4);
      exp_done += v[k].n;
      chk("nwr", wq.size(), v[k].n);
      chk("nrd", rq.size(), v[k].exp_rd);
      for (int i = 0; i < wq.size() && i < v[k].n; i++) begin
        chk("wr_addr", wq[i][20:8], v[k].exp_va + 13'(i));
        chk("wr_bank", wq[i][21], v[k].bank);
        chk("wr_data", wq[i][7:0], v[k].exp_ff ? 8'hFF : pat(v[k].exp_ma + 16'(i)));
      end
      for (int i = 0; i < rq.size() && i < v[k].exp_rd; i++)
        chk("rd_addr", rq[i], v[k].exp_ma + 16'(i));
      chk("done", bytes_done, exp_done);
      chk("err", err, v[k].exp_err);
      chk("halt_idle", cpu_halt, 0);
      if (v[k].exp_lat != 0) chk("latency", we_cyc - rd_cyc, v[k].exp_lat);
    end

    wq.delete(); bus_en = 1'b1; vram_busy = 1'b1; vram_bank = 1'b1; hdma_active = 1'b1;
    src_addr = 16'h6000; dst_addr = 16'h8123; hdma_rd = 1'b1;
    tick(3);
    hdma_rd = 1'b0; hdma_active = 1'b0;
    tick(10);
    chk("busy_nwr", wq.size(), 0);
    chk("busy_halt", cpu_halt, 1);
    vram_busy = 1'b0;
    tick(2);
    exp_done += 1;
    chk("busy_nwr_after", wq.size(), 1);
    if (wq.size() > 0) begin
      chk("busy_data", wq[0][7:0], pat(16'h6000));
      chk("busy_addr", wq[0][20:8], 13'h0123);
      chk("busy_bank", wq[0][21], 1);
    end
    chk("busy_halt_end", cpu_halt, 0);
    chk("busy_done", bytes_done, exp_done);
    chk("err_sticky", err, 1);

    wq.delete(); vram_bank = 1'b0; hdma_active = 1'b1;
    src_addr = 16'h4100; dst_addr = 16'h8200; hdma_rd = 1'b1;
    tick(2);
    src_addr = 16'h4101; dst_addr = 16'h8201;
    tick(6);
    hdma_rd = 1'b0;
    tick(1);
    src_addr = 16'h4100; dst_addr = 16'h8200; hdma_rd = 1'b1;
    tick(5);
    hdma_rd = 1'b0; hdma_active = 1'b0;
    tick(2);
    exp_done += 3;
    chk("skid_nwr", wq.size(), 3);
    if (wq.size() == 3) begin
      chk("skid_a0", wq[0][20:0], {13'h0200, pat(16'h4100)});
      chk("skid_a1", wq[1][20:0], {13'h0201, pat(16'h4101)});
      chk("skid_a2", wq[2][20:0], {13'h0200, pat(16'h4100)});
    end
    chk("skid_done", bytes_done, exp_done);

    wq.delete(); hdma_active = 1'b1;
    src_addr = 16'h4200; dst_addr = 16'h8300; hdma_rd = 1'b1;
    tick(3);
    ce = 1'b0;
    tick(3);
    chk("ce_hold_nwr", wq.size(), 0);
    chk("ce_hold_done", bytes_done, exp_done);
    ce = 1'b1;
    tick(2);
    exp_done += 1;
    chk("ce_nwr", wq.size(), 1);
    chk("ce_done", bytes_done, exp_done);
    hdma_rd = 1'b0; hdma_active = 1'b0;
    tick(2);

    wq.delete(); bus_en = 1'b0; hdma_active = 1'b1;
    src_addr = 16'h4300; dst_addr = 16'h8400; hdma_rd = 1'b1;
    tick(4);
    reset = 1'b1; hdma_active = 1'b0; hdma_rd = 1'b0;
    tick(1);
    chk("rw_halt", cpu_halt, 0);
    chk("rw_done", bytes_done, 0);
    chk("rw_err", err, 0);
    chk("rw_maddr", mem_addr, 0);
    reset = 1'b0;
    tick(20);
    chk("rw_nwr", wq.size(), 0);
    bus_en = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
